// File: rtl/ctrl_unit_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes and immediate formats.
// Also imported by the ALU and the immediate generator.
package ctrl_unit_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_sel_e;

endpackage

// File: rtl/ctrl_alu_dec.sv
// ALU operation decoder: opcode/funct3/funct7[5] -> ALU operation.
// Anything that is not R-type, I-type ALU or LUI computes an address or sum, so it gets ADD.
module ctrl_alu_dec
    import ctrl_unit_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       alt,
    output alu_op_e    alu_op
);

    logic is_r;
    logic is_i;

    assign is_r = (opcode == OP_R);
    assign is_i = (opcode == OP_I);

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_LUI) begin
            alu_op = ALU_PASSB;
        end else if (is_r || is_i) begin
            case (funct3)
                // The immediate occupies funct7 on ADDI, so only R-type may select SUB.
                3'b000:  alu_op = (is_r && alt) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_unit.sv
// Main RV32I decoder: combinational datapath controls and branch resolution,
// plus a sticky flag recording that an unsupported opcode was seen.
module ctrl_unit
    import ctrl_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       brEq,
    input  logic       brLt,
    output logic       branch,
    output logic       MemRead,
    output logic       MemtoReg,
    output logic       MemWrite,
    output logic       ALUsrc,
    output logic       RegWrite,
    output logic       ResultSrc,
    output logic [3:0] ALUop,
    output logic [2:0] immsel,
    output logic       asel,
    output logic       brUn,
    output logic       illegal
);

    alu_op_e  alu_op;
    imm_sel_e imm_sel;
    logic     bad_op;
    logic     br_taken;
    logic     illegal_q;
    logic     unused_funct7_bits;

    assign unused_funct7_bits = ^{funct7[6], funct7[4:0]};

    ctrl_alu_dec u_alu_dec (
        .opcode (opcode),
        .funct3 (funct3),
        .alt    (funct7[5]),
        .alu_op (alu_op)
    );

    always_comb begin
        case (funct3)
            3'b000:         br_taken = brEq;
            3'b001:         br_taken = !brEq;
            3'b100, 3'b110: br_taken = brLt;
            3'b101, 3'b111: br_taken = !brLt;
            default:        br_taken = 1'b0;
        endcase
    end

    always_comb begin
        branch    = 1'b0;
        MemRead   = 1'b0;
        MemtoReg  = 1'b0;
        MemWrite  = 1'b0;
        ALUsrc    = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 1'b0;
        asel      = 1'b0;
        brUn      = 1'b0;
        imm_sel   = IMM_I;
        bad_op    = 1'b0;
        case (opcode)
            OP_R: RegWrite = 1'b1;
            OP_I: begin
                RegWrite = 1'b1;
                ALUsrc   = 1'b1;
            end
            OP_LD: begin
                RegWrite = 1'b1;
                ALUsrc   = 1'b1;
                MemRead  = 1'b1;
                MemtoReg = 1'b1;
            end
            OP_ST: begin
                MemWrite = 1'b1;
                ALUsrc   = 1'b1;
                imm_sel  = IMM_S;
            end
            OP_BR: begin
                imm_sel = IMM_B;
                brUn    = funct3[1];
                branch  = br_taken;
            end
            OP_JAL: begin
                branch    = 1'b1;
                RegWrite  = 1'b1;
                ResultSrc = 1'b1;
                imm_sel   = IMM_J;
            end
            OP_JALR: begin
                branch    = 1'b1;
                RegWrite  = 1'b1;
                ResultSrc = 1'b1;
                ALUsrc    = 1'b1;
            end
            OP_LUI: begin
                RegWrite = 1'b1;
                ALUsrc   = 1'b1;
                imm_sel  = IMM_U;
            end
            OP_AUIPC: begin
                RegWrite = 1'b1;
                ALUsrc   = 1'b1;
                asel     = 1'b1;
                imm_sel  = IMM_U;
            end
            default: bad_op = 1'b1;
        endcase
        ALUop  = alu_op;
        immsel = imm_sel;
        // Reset gates the combinational outputs directly so they drop with no clock.
        if (rst) begin
            branch    = 1'b0;
            MemRead   = 1'b0;
            MemtoReg  = 1'b0;
            MemWrite  = 1'b0;
            ALUsrc    = 1'b0;
            RegWrite  = 1'b0;
            ResultSrc = 1'b0;
            asel      = 1'b0;
            brUn      = 1'b0;
            ALUop     = '0;
            immsel    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (bad_op) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: a decode vector table plus hand-written sequences
// for the sticky illegal flag and asynchronous reset.
module tb_ctrl_unit;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       brEq;
    logic       brLt;
    logic       branch, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite, ResultSrc;
    logic [3:0] ALUop;
    logic [2:0] immsel;
    logic       asel, brUn, illegal;

    int unsigned total;
    int unsigned bad;

    // {branch,MemRead,MemtoReg,MemWrite,ALUsrc,RegWrite,ResultSrc,ALUop,immsel,asel,brUn,illegal}
    logic [16:0] got;
    assign got = {branch, MemRead, MemtoReg, MemWrite, ALUsrc, RegWrite, ResultSrc,
                  ALUop, immsel, asel, brUn, illegal};

    ctrl_unit dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .brEq      (brEq),
        .brLt      (brLt),
        .branch    (branch),
        .MemRead   (MemRead),
        .MemtoReg  (MemtoReg),
        .MemWrite  (MemWrite),
        .ALUsrc    (ALUsrc),
        .RegWrite  (RegWrite),
        .ResultSrc (ResultSrc),
        .ALUop     (ALUop),
        .immsel    (immsel),
        .asel      (asel),
        .brUn      (brUn),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       eq;
        logic       lt;
        logic       br, mr, m2r, mw, asrc, rw, rs;
        logic [3:0] aop;
        logic [2:0] imm;
        logic       asl, un;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic eq, input logic lt);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
        brEq   = eq;
        brLt   = lt;
    endtask

    localparam logic [16:0] R_ADD  = 17'b0_0_0_0_0_1_0_0000_000_0_0_0;
    localparam logic [16:0] ZEROS  = 17'b0;

    initial begin
        total = 0;
        bad   = 0;
        //        name         op          f3      f7          eq  lt  br mr m2r mw as rw rs aop      imm     asl un
        vecs[0]  = '{"r_add",  7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 0, 0};
        vecs[1]  = '{"r_sub",  7'b0110011, 3'b000, 7'b0100000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0001, 3'b000, 0, 0};
        vecs[2]  = '{"r_sra",  7'b0110011, 3'b101, 7'b0100000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0111, 3'b000, 0, 0};
        vecs[3]  = '{"r_srl",  7'b0110011, 3'b101, 7'b0000000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0110, 3'b000, 0, 0};
        vecs[4]  = '{"r_and",  7'b0110011, 3'b111, 7'b0000000, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1001, 3'b000, 0, 0};
        vecs[5]  = '{"r_sltu", 7'b0110011, 3'b011, 7'b0000000, 1, 1, 0, 0, 0, 0, 0, 1, 0, 4'b0100, 3'b000, 0, 0};
        vecs[6]  = '{"i_addi", 7'b0010011, 3'b000, 7'b0100000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 3'b000, 0, 0};
        vecs[7]  = '{"i_srai", 7'b0010011, 3'b101, 7'b0100000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0111, 3'b000, 0, 0};
        vecs[8]  = '{"i_xori", 7'b0010011, 3'b100, 7'b0100000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0101, 3'b000, 0, 0};
        vecs[9]  = '{"i_slli", 7'b0010011, 3'b001, 7'b0000000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0010, 3'b000, 0, 0};
        vecs[10] = '{"ld",     7'b0000011, 3'b010, 7'b0000000, 0, 0, 0, 1, 1, 0, 1, 1, 0, 4'b0000, 3'b000, 0, 0};
        vecs[11] = '{"st",     7'b0100011, 3'b010, 7'b0100000, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 3'b001, 0, 0};
        vecs[12] = '{"beq_t",  7'b1100011, 3'b000, 7'b0000000, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b010, 0, 0};
        vecs[13] = '{"beq_n",  7'b1100011, 3'b000, 7'b0000000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b010, 0, 0};
        vecs[14] = '{"bne_t",  7'b1100011, 3'b001, 7'b0000000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b010, 0, 0};
        vecs[15] = '{"blt_t",  7'b1100011, 3'b100, 7'b0000000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b010, 0, 0};
        vecs[16] = '{"bgeu_t", 7'b1100011, 3'b111, 7'b0000000, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b010, 0, 1};
        vecs[17] = '{"bgeu_n", 7'b1100011, 3'b111, 7'b0000000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b010, 0, 1};
        vecs[18] = '{"br_f2",  7'b1100011, 3'b010, 7'b0000000, 1, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b010, 0, 1};
        vecs[19] = '{"bltu_t", 7'b1100011, 3'b110, 7'b0000000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 3'b010, 0, 1};
        vecs[20] = '{"jal",    7'b1101111, 3'b101, 7'b0100000, 0, 0, 1, 0, 0, 0, 0, 1, 1, 4'b0000, 3'b100, 0, 0};
        vecs[21] = '{"jalr",   7'b1100111, 3'b000, 7'b0000000, 0, 0, 1, 0, 0, 0, 1, 1, 1, 4'b0000, 3'b000, 0, 0};
        vecs[22] = '{"lui",    7'b0110111, 3'b101, 7'b0100000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b1010, 3'b011, 0, 0};
        vecs[23] = '{"auipc",  7'b0010111, 3'b101, 7'b0100000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 3'b011, 1, 0};

        // Reset state with an R-type on the inputs.
        rst = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
        @(negedge clk);
        check("reset_state", got, ZEROS);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_r_add", got, R_ADD);

        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1 drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].eq, vecs[i].lt);
            @(negedge clk);
            check(vecs[i].name, got,
                  {vecs[i].br, vecs[i].mr, vecs[i].m2r, vecs[i].mw, vecs[i].asrc, vecs[i].rw,
                   vecs[i].rs, vecs[i].aop, vecs[i].imm, vecs[i].asl, vecs[i].un, 1'b0});
        end

        // Unsupported opcode: NOP decode now, flag only after the next rising edge.
        @(posedge clk);
        #1 drive(7'b1111111, 3'b000, 7'b0000000, 1'b1, 1'b1);
        @(negedge clk);
        check("illegal_pre_edge", got, ZEROS);
        @(posedge clk);
        #1;
        check("illegal_set", got, 17'b1);
        drive(7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0);
        @(negedge clk);
        check("illegal_sticky_r_sub", got, 17'b0_0_0_0_0_1_0_0001_000_0_0_1);
        @(posedge clk);
        #1 drive(7'b0000011, 3'b010, 7'b0000000, 1'b0, 1'b0);
        @(negedge clk);
        check("illegal_sticky_ld", got, 17'b0_1_1_0_1_1_0_0000_000_0_0_1);

        // Asynchronous reset mid-cycle during an R-type, no clock edge in between.
        @(posedge clk);
        #1 drive(7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("async_rst_zero", got, ZEROS);
        #1 rst = 1'b0;
        #1 check("async_rst_release", got, R_ADD);

        // Reset held across an edge that sees an illegal opcode: reset wins.
        @(posedge clk);
        #1 begin
            rst = 1'b1;
            drive(7'b0000000, 3'b000, 7'b0000000, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1 check("rst_beats_illegal", got, ZEROS);
        drive(7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1 check("after_rst_no_illegal", got, R_ADD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
